// File: rtl/rf_pkg.sv
// Shared definitions for the scoreboarded register file: default geometry,
// clear-sequencer states and the hardwired zero register index.
package rf_pkg;
    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);
    localparam int ZERO_REG  = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: decode allocation sets, writeback release clears,
// and the clear sequencer zeroes one index per cycle.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NWR   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_alloc_en,
    input  logic [AW-1:0]     i_alloc_addr,
    input  logic [NWR-1:0]    i_rel_en,
    input  logic [NWR*AW-1:0] i_rel_addr,
    input  logic              i_clr_en,
    input  logic [AW-1:0]     i_clr_addr,
    output logic [NREGS-1:0]  o_busy_vec
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // Priority low to high: release, allocate (new producer supersedes), clear.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 1; i < NREGS; i++) begin
            for (int k = 0; k < NWR; k++) begin
                if (i_rel_en[k] && i_rel_addr[k*AW +: AW] == AW'(i))
                    w_busy_nxt[i] = 1'b0;
            end
            if (i_alloc_en && i_alloc_addr == AW'(i))
                w_busy_nxt[i] = 1'b1;
            if (i_clr_en && i_clr_addr == AW'(i))
                w_busy_nxt[i] = 1'b0;
        end
        w_busy_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    assign o_busy_vec = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with write bypass, scoreboard and a
// hardware clear sequencer that zeroes registers 1..NREGS-1 one per cycle.
//   state    | meaning
//   ST_IDLE  | normal operation, clr_req starts a sweep
//   ST_CLEAR | zeroing register r_ptr; writes, allocs and bypass suppressed
module regfile_sb
    import rf_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREGS  = NREGS_DEF,
    parameter  int NRD    = 2,
    parameter  int NWR    = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [NWR-1:0]      i_wr_en,
    input  logic [NWR*AW-1:0]   i_wr_addr,
    input  logic [NWR*XLEN-1:0] i_wr_data,
    input  logic [NRD*AW-1:0]   i_rd_addr,
    output logic [NRD*XLEN-1:0] o_rd_data,
    output logic [NRD-1:0]      o_rd_busy,
    input  logic                i_alloc_en,
    input  logic [AW-1:0]       i_alloc_addr,
    input  logic                i_clr_req,
    output logic                o_clr_busy,
    output logic                o_clr_done,
    output logic [NREGS-1:0]    o_busy_vec
);

    logic [XLEN-1:0]  r_regs [NREGS];
    clr_state_t       r_state;
    clr_state_t       w_state_nxt;
    logic [AW-1:0]    r_ptr;
    logic             r_clr_done;
    logic             w_clearing;
    logic             w_sweep_last;
    logic [NWR-1:0]   w_wr_act;
    logic             w_alloc_act;
    logic [NREGS-1:0] w_busy_vec;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_clr_req) w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (r_ptr == AW'(NREGS-1)) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_clearing = (r_state == ST_CLEAR);
    end

    assign o_clr_busy   = w_clearing;
    assign o_clr_done   = r_clr_done;
    assign w_sweep_last = w_clearing && (r_ptr == AW'(NREGS-1));
    assign w_wr_act     = i_wr_en & {NWR{~w_clearing}};
    assign w_alloc_act  = i_alloc_en & ~w_clearing;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ptr      <= '0;
            r_clr_done <= 1'b0;
        end else begin
            r_clr_done <= w_sweep_last;
            if (r_state == ST_IDLE && i_clr_req)
                r_ptr <= AW'(1);
            else if (w_clearing)
                r_ptr <= r_ptr + AW'(1);
        end
    end

    // Ascending port loop makes the highest-indexed writer win on collisions.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else if (w_clearing) begin
            r_regs[r_ptr] <= '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (w_wr_act[k] && i_wr_addr[k*AW +: AW] != AW'(ZERO_REG))
                    r_regs[i_wr_addr[k*AW +: AW]] <= i_wr_data[k*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        o_rd_data = '0;
        o_rd_busy = '0;
        for (int j = 0; j < NRD; j++) begin
            o_rd_data[j*XLEN +: XLEN] = r_regs[i_rd_addr[j*AW +: AW]];
            o_rd_busy[j]              = w_busy_vec[i_rd_addr[j*AW +: AW]];
            if (BYPASS != 0) begin
                for (int k = 0; k < NWR; k++) begin
                    if (w_wr_act[k] && i_wr_addr[k*AW +: AW] == i_rd_addr[j*AW +: AW]) begin
                        o_rd_data[j*XLEN +: XLEN] = i_wr_data[k*XLEN +: XLEN];
                        o_rd_busy[j]              = 1'b0;
                    end
                end
            end
            if (i_rd_addr[j*AW +: AW] == AW'(ZERO_REG)) begin
                o_rd_data[j*XLEN +: XLEN] = '0;
                o_rd_busy[j]              = 1'b0;
            end
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_alloc_en   (w_alloc_act),
        .i_alloc_addr (i_alloc_addr),
        .i_rel_en     (w_wr_act),
        .i_rel_addr   (i_wr_addr),
        .i_clr_en     (w_clearing),
        .i_clr_addr   (r_ptr),
        .o_busy_vec   (w_busy_vec)
    );

    assign o_busy_vec = w_busy_vec;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed steps on the default geometry (with a BYPASS=0
// twin on the same inputs) and a randomized run of a 16x32 1W/3R instance.
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [127:0] wr_data;
    logic [9:0]   rd_addr;
    logic [127:0] rd_data, nb_rd_data;
    logic [1:0]   rd_busy, nb_rd_busy;
    logic         alloc_en;
    logic [4:0]   alloc_addr;
    logic         clr_req;
    logic         clr_busy, clr_done, nb_clr_busy, nb_clr_done;
    logic [31:0]  busy_vec, nb_busy_vec;

    logic [0:0]   p_wr_en;
    logic [3:0]   p_wr_addr;
    logic [31:0]  p_wr_data;
    logic [11:0]  p_rd_addr;
    logic [95:0]  p_rd_data;
    logic [2:0]   p_rd_busy;
    logic         p_alloc_en;
    logic [3:0]   p_alloc_addr;
    logic         p_clr_req, p_clr_busy, p_clr_done;
    logic [15:0]  p_busy_vec;

    regfile_sb dut (
        .i_clk(clk), .i_reset(reset), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
        .o_rd_busy(rd_busy), .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr),
        .i_clr_req(clr_req), .o_clr_busy(clr_busy), .o_clr_done(clr_done),
        .o_busy_vec(busy_vec)
    );

    regfile_sb #(.BYPASS(0)) dut_nb (
        .i_clk(clk), .i_reset(reset), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_rd_addr(rd_addr), .o_rd_data(nb_rd_data),
        .o_rd_busy(nb_rd_busy), .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr),
        .i_clr_req(clr_req), .o_clr_busy(nb_clr_busy), .o_clr_done(nb_clr_done),
        .o_busy_vec(nb_busy_vec)
    );

    regfile_sb #(.XLEN(32), .NREGS(16), .NRD(3), .NWR(1), .BYPASS(1)) dut_p (
        .i_clk(clk), .i_reset(reset), .i_wr_en(p_wr_en), .i_wr_addr(p_wr_addr),
        .i_wr_data(p_wr_data), .i_rd_addr(p_rd_addr), .o_rd_data(p_rd_data),
        .o_rd_busy(p_rd_busy), .i_alloc_en(p_alloc_en), .i_alloc_addr(p_alloc_addr),
        .i_clr_req(p_clr_req), .o_clr_busy(p_clr_busy), .o_clr_done(p_clr_done),
        .o_busy_vec(p_busy_vec)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] fill_val(input int i);
        return 64'hC0DE_0000 + 64'(i);
    endfunction

    logic [31:0] pm_reg [16];
    logic [15:0] pm_busy;
    int          sweep_pos;
    logic        exp_done;
    int          busy_cnt, done_cnt;
    logic        seen;
    logic [3:0]  a;
    logic [31:0] ed;
    logic        eb;

    initial begin
        wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        alloc_en = 1'b0; alloc_addr = '0; clr_req = 1'b0;
        p_wr_en = '0; p_wr_addr = '0; p_wr_data = '0; p_rd_addr = '0;
        p_alloc_en = 1'b0; p_alloc_addr = '0; p_clr_req = 1'b0;
        reset = 1'b1;
        rd_addr[4:0] = 5'd5;
        #3;
        chk("rst_rd", rd_data[63:0], 64'h0);
        chk("rst_busy_vec", 64'(busy_vec), 64'h0);
        chk("rst_clr_busy", 64'(clr_busy), 64'h0);
        chk("rst_clr_done", 64'(clr_done), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // both ports write x5: port 1 must win
        wr_en = 2'b11; wr_addr = {5'd5, 5'd5}; wr_data = {64'hBEEF, 64'h1234};
        step();
        wr_en = '0; rd_addr[4:0] = 5'd5;
        #1 chk("wr_prio", rd_data[63:0], 64'hBEEF);

        wr_en = 2'b01; wr_addr[4:0] = 5'd0; wr_data[63:0] = 64'hFF; rd_addr = '0;
        #1 chk("x0_bypass", rd_data[127:64], 64'h0);
        step();
        wr_en = '0;
        #1 chk("x0_store", rd_data[63:0], 64'h0);

        alloc_en = 1'b1; alloc_addr = 5'd7;
        step();
        alloc_en = 1'b0;
        wr_en = 2'b01; wr_addr[4:0] = 5'd7; wr_data[63:0] = 64'hAA55; rd_addr[9:5] = 5'd7;
        #1;
        chk("bypass_data", rd_data[127:64], 64'hAA55);
        chk("bypass_busy", 64'(rd_busy[1]), 64'h0);
        chk("nobypass_data", nb_rd_data[127:64], 64'h0);
        chk("nobypass_busy", 64'(nb_rd_busy[1]), 64'h1);
        step();
        wr_en = '0;
        #1;
        chk("nobypass_stored", nb_rd_data[127:64], 64'hAA55);
        chk("x7_released", 64'(busy_vec[7]), 64'h0);

        alloc_en = 1'b1; alloc_addr = 5'd9;
        step();
        alloc_en = 1'b0; rd_addr[4:0] = 5'd9;
        #1;
        chk("alloc_vec", 64'(busy_vec[9]), 64'h1);
        chk("alloc_rd_busy", 64'(rd_busy[0]), 64'h1);
        wr_en = 2'b01; wr_addr[4:0] = 5'd9; wr_data[63:0] = 64'h99;
        step();
        wr_en = '0;
        #1 chk("release", 64'(busy_vec[9]), 64'h0);
        alloc_en = 1'b1; alloc_addr = 5'd9;
        wr_en = 2'b01; wr_addr[4:0] = 5'd9; wr_data[63:0] = 64'h100;
        step();
        alloc_en = 1'b0; wr_en = '0;
        #1;
        chk("alloc_wins", 64'(busy_vec[9]), 64'h1);
        chk("alloc_wr_data", rd_data[63:0], 64'h100);

        for (int i = 1; i < 32; i += 2) begin
            wr_en = 2'b11;
            wr_addr = {5'(i + 1), 5'(i)};
            wr_data = {fill_val(i + 1), fill_val(i)};
            step();
        end
        wr_en = '0;
        alloc_en = 1'b1; alloc_addr = 5'd12;
        step();
        alloc_en = 1'b0; rd_addr = {5'd31, 5'd1};
        #1;
        chk("load_x1", rd_data[63:0], fill_val(1));
        chk("load_x31", rd_data[127:64], fill_val(31));

        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 100 && done_cnt == 0; c++) begin
            if (clr_busy) busy_cnt++;
            if (clr_done) begin
                done_cnt++;
                chk("done_busy_drop", 64'(clr_busy), 64'h0);
            end
            if (c == 9) begin
                wr_en = 2'b01; wr_addr[4:0] = 5'd3; wr_data[63:0] = 64'hDEAD;
                alloc_en = 1'b1; alloc_addr = 5'd4; rd_addr[4:0] = 5'd3;
                #1 chk("sweep_no_bypass", rd_data[63:0], 64'h0);
            end
            step();
            wr_en = '0; alloc_en = 1'b0;
        end
        chk("sweep_len", 64'(busy_cnt), 64'd31);
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("done_one_cycle", 64'(clr_done), 64'h0);
        for (int r = 0; r < 32; r++) begin
            rd_addr[4:0] = 5'(r);
            #1 chk("post_clr_rd", rd_data[63:0], 64'h0);
        end
        chk("post_clr_busy_vec", 64'(busy_vec), 64'h0);

        wr_en = 2'b01; wr_addr[4:0] = 5'd30; wr_data[63:0] = 64'h30;
        alloc_en = 1'b1; alloc_addr = 5'd29;
        step();
        wr_en = '0; alloc_en = 1'b0;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (9) step();
        chk("mid_sweep_busy", 64'(clr_busy), 64'h1);
        #2 reset = 1'b1;
        rd_addr[4:0] = 5'd30;
        #1;
        chk("rst_mid_clr_busy", 64'(clr_busy), 64'h0);
        chk("rst_mid_busy_vec", 64'(busy_vec), 64'h0);
        chk("rst_mid_rd", rd_data[63:0], 64'h0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (clr_done) seen = 1'b1;
        end
        chk("no_done_after_rst", 64'(seen), 64'h0);

        wr_en = 2'b11; wr_addr = {5'd2, 5'd1}; wr_data = {64'h22, 64'h11};
        step();
        wr_en = '0;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        step();
        rd_addr = {5'd2, 5'd1};
        #1;
        chk("restart_x1", rd_data[63:0], 64'h0);
        chk("restart_x2", rd_data[127:64], 64'h22);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (clr_done) seen = 1'b1;
            else step();
        end
        chk("restart_done", 64'(seen), 64'h1);

        for (int i = 0; i < 16; i++) pm_reg[i] = '0;
        pm_busy = '0; sweep_pos = 0; exp_done = 1'b0;
        step();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            p_wr_en      = 1'($urandom_range(0, 1));
            p_wr_addr    = 4'($urandom);
            p_wr_data    = $urandom;
            p_rd_addr    = 12'($urandom);
            if ($urandom_range(0, 2) == 0) p_rd_addr[3:0] = p_wr_addr;
            p_alloc_en   = ($urandom_range(0, 3) == 0);
            p_alloc_addr = ($urandom_range(0, 3) == 0) ? p_wr_addr : 4'($urandom);
            p_clr_req    = ($urandom_range(0, 199) == 0);
            #1;
            for (int j = 0; j < 3; j++) begin
                a = p_rd_addr[j*4 +: 4];
                if (a == 4'd0) begin
                    ed = '0; eb = 1'b0;
                end else if (sweep_pos == 0 && p_wr_en[0] && p_wr_addr == a) begin
                    ed = p_wr_data; eb = 1'b0;
                end else begin
                    ed = pm_reg[a]; eb = pm_busy[a];
                end
                chk("rand_rd_data", 64'(p_rd_data[j*32 +: 32]), 64'(ed));
                chk("rand_rd_busy", 64'(p_rd_busy[j]), 64'(eb));
            end
            chk("rand_busy_vec", 64'(p_busy_vec), 64'(pm_busy));
            chk("rand_clr_busy", 64'(p_clr_busy), 64'(sweep_pos != 0));
            chk("rand_clr_done", 64'(p_clr_done), 64'(exp_done));
            @(posedge clk);
            exp_done = 1'b0;
            if (sweep_pos != 0) begin
                pm_reg[sweep_pos]  = '0;
                pm_busy[sweep_pos] = 1'b0;
                sweep_pos++;
                if (sweep_pos == 16) begin
                    sweep_pos = 0;
                    exp_done  = 1'b1;
                end
            end else begin
                if (p_wr_en[0] && p_wr_addr != 4'd0) begin
                    pm_reg[p_wr_addr]  = p_wr_data;
                    pm_busy[p_wr_addr] = 1'b0;
                end
                if (p_alloc_en && p_alloc_addr != 4'd0) pm_busy[p_alloc_addr] = 1'b1;
                if (p_clr_req) sweep_pos = 1;
            end
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
